// File: rtl/echo_acq_pkg.sv
// -----------------------------------------------------------------------------
// echo_acq_pkg
// Shared definitions for the echo acquisition gate:
//   - acquisition FSM state type
//   - default ADC sample width
//   - field layout of the 32-bit output stream word
//   - bit positions inside the sticky error vector
// -----------------------------------------------------------------------------
package echo_acq_pkg;

    // Default ADC sample width.
    localparam int unsigned DATA_W_DEF    = 16;

    // Output stream word: {echo_idx[15:0], sample[15:0]}.
    localparam int unsigned TDATA_W       = 32;
    localparam int unsigned TD_SAMPLE_LSB = 0;
    localparam int unsigned TD_SAMPLE_W   = 16;
    localparam int unsigned TD_IDX_LSB    = 16;
    localparam int unsigned TD_IDX_W      = 16;

    // Sticky error flags, err = {overlap, overflow}.
    localparam int unsigned ERR_W         = 2;
    localparam int unsigned ERR_OVERFLOW  = 0;
    localparam int unsigned ERR_OVERLAP   = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_PULSE,
        ST_BLANK,
        ST_ACQ,
        ST_DONE
    } acq_state_t;

endpackage

// File: rtl/echo_fifo.sv
// -----------------------------------------------------------------------------
// echo_fifo
// Single-clock first-word-fall-through FIFO. The head entry is presented on
// o_rd_data whenever o_empty=0 and is consumed by i_rd_en. Writes while full
// and reads while empty are ignored. o_rd_data reads as zero when empty so
// downstream data is clean after reset.
//
// Parameters
//   DEPTH      number of entries (power of two, >= 4)
//   WIDTH      entry width in bits
// Ports
//   i_clk      clock, posedge
//   i_rst_n    asynchronous active-low reset (empties the FIFO)
//   i_wr_en    write request
//   i_wr_data  write data
//   i_rd_en    read (pop) request
//   o_rd_data  head entry (FWFT)
//   o_full     FIFO holds DEPTH entries
//   o_empty    FIFO holds no entries
// -----------------------------------------------------------------------------
module echo_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 33
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_wr;
    logic w_rd;

    assign w_wr    = i_wr_en && !o_full;
    assign w_rd    = i_rd_en && !o_empty;
    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);

    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

    // Storage has no reset; validity is tracked solely by r_count.
    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/echo_acq_gate.sv
// -----------------------------------------------------------------------------
// echo_acq_gate
// Gates ADC samples into per-echo windows of a CPMG pulse train. After an arm
// strobe the first pulse end (excitation) is skipped; every later pulse end
// starts a blanking interval followed by a window of win_len accepted samples.
// Samples leave through an AXI-Stream style FWFT FIFO tagged with the echo
// index; the last sample of each window carries m_tlast.
//
// Optional feature (macro ACQ_ECHO_SUM_EN): per-echo signed sum of every
// accepted window sample on sum_data/sum_valid. Without the macro both are
// tied to zero.
//
// Parameters
//   FIFO_DEPTH     output FIFO depth (power of two, >= 4)
//   DATA_W         ADC sample width (<= 32)
// Ports
//   clk            clock, posedge
//   rst            asynchronous active-low reset
//   pulse_data     transmit amplitude; non-zero = pulse on
//   adc_data       signed receiver sample
//   adc_valid      adc_data valid
//   arm            start strobe, latches blank_cycles/win_len/num_echoes
//   blank_cycles   ring-down blanking length in clocks
//   win_len        samples per echo (0 treated as 1)
//   num_echoes     echoes per train
//   m_tdata        {echo_idx, sign-extended sample}
//   m_tvalid       stream valid
//   m_tready       stream ready
//   m_tlast        last sample of an echo window
//   busy           train in progress
//   done           one-cycle train-complete pulse
//   err            sticky {overlap, overflow}
//   sum_data       per-echo sample sum
//   sum_valid      one-cycle sum strobe
// -----------------------------------------------------------------------------
module echo_acq_gate
    import echo_acq_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned DATA_W     = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [15:0]              pulse_data,
    input  logic signed [DATA_W-1:0] adc_data,
    input  logic                     adc_valid,
    input  logic                     arm,
    input  logic [15:0]              blank_cycles,
    input  logic [15:0]              win_len,
    input  logic [15:0]              num_echoes,
    output logic [TDATA_W-1:0]       m_tdata,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic                     m_tlast,
    output logic                     busy,
    output logic                     done,
    output logic [ERR_W-1:0]         err,
    output logic [31:0]              sum_data,
    output logic                     sum_valid
);

    localparam int unsigned FIFO_W = TDATA_W + 1;

    acq_state_t        r_state;
    acq_state_t        w_state_nxt;

    logic [15:0]       r_pulse_prev;
    logic [15:0]       r_blank_len;
    logic [15:0]       r_win_len;
    logic [15:0]       r_num;
    logic [15:0]       r_echo_idx;
    logic [15:0]       r_blank_cnt;
    logic [15:0]       r_samp_cnt;
    logic              r_skip;
    logic              r_busy;
    logic              r_done;
    logic [ERR_W-1:0]  r_err;
    logic              r_wr_en;
    logic [FIFO_W-1:0] r_wr_word;

    logic              w_pulse_end;
    logic              w_arm_acc;
    logic              w_skip_clr;
    logic              w_blank_start;
    logic              w_acq_start;
    logic              w_accept;
    logic              w_last;
    logic              w_overlap;
    logic [TD_SAMPLE_W-1:0] w_sample16;
    logic [FIFO_W-1:0] w_wr_word;
    logic [FIFO_W-1:0] w_rd_word;
    logic              w_full;
    logic              w_empty;

    // Falling edge of the transmit envelope.
    assign w_pulse_end = (pulse_data == '0) && (r_pulse_prev != '0);

    // Signed size cast: sign-extends narrow samples, truncates wide ones.
    assign w_sample16 = TD_SAMPLE_W'(adc_data);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and datapath strobes
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_arm_acc     = 1'b0;
        w_skip_clr    = 1'b0;
        w_blank_start = 1'b0;
        w_acq_start   = 1'b0;
        w_accept      = 1'b0;
        w_last        = 1'b0;
        w_overlap     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (arm) begin
                    w_arm_acc   = 1'b1;
                    w_state_nxt = (num_echoes == '0) ? ST_DONE : ST_WAIT_PULSE;
                end
            end
            ST_WAIT_PULSE: begin
                if (w_pulse_end) begin
                    if (r_skip) begin
                        // Excitation pulse: consume it, keep waiting.
                        w_skip_clr = 1'b1;
                    end else if (r_blank_len == '0) begin
                        w_acq_start = 1'b1;
                        w_state_nxt = ST_ACQ;
                    end else begin
                        w_blank_start = 1'b1;
                        w_state_nxt   = ST_BLANK;
                    end
                end
            end
            ST_BLANK: begin
                w_overlap = w_pulse_end;
                if (r_blank_cnt == '0) begin
                    w_acq_start = 1'b1;
                    w_state_nxt = ST_ACQ;
                end
            end
            ST_ACQ: begin
                w_overlap = w_pulse_end;
                if (adc_valid) begin
                    w_accept = 1'b1;
                    if (r_samp_cnt == r_win_len - 16'd1) begin
                        w_last      = 1'b1;
                        w_state_nxt = (r_echo_idx + 16'd1 == r_num) ? ST_DONE
                                                                    : ST_WAIT_PULSE;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_wr_word = '0;
        w_wr_word[TDATA_W]                      = w_last;
        w_wr_word[TD_IDX_LSB +: TD_IDX_W]       = r_echo_idx;
        w_wr_word[TD_SAMPLE_LSB +: TD_SAMPLE_W] = w_sample16;
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pulse_prev <= '0;
            r_blank_len  <= '0;
            r_win_len    <= 16'd1;
            r_num        <= '0;
            r_echo_idx   <= '0;
            r_blank_cnt  <= '0;
            r_samp_cnt   <= '0;
            r_skip       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= '0;
            r_wr_en      <= 1'b0;
            r_wr_word    <= '0;
        end else begin
            r_pulse_prev <= pulse_data;
            // done and the busy drop both follow the single DONE cycle.
            r_done       <= (r_state == ST_DONE);

            if (w_arm_acc) begin
                r_blank_len <= blank_cycles;
                r_win_len   <= (win_len == '0) ? 16'd1 : win_len;
                r_num       <= num_echoes;
                r_echo_idx  <= '0;
                r_skip      <= 1'b1;
                r_busy      <= 1'b1;
            end else begin
                if (r_state == ST_DONE) begin
                    r_busy <= 1'b0;
                end
                if (w_skip_clr) begin
                    r_skip <= 1'b0;
                end
                if (w_last) begin
                    r_echo_idx <= r_echo_idx + 16'd1;
                end
            end

            if (w_blank_start) begin
                r_blank_cnt <= r_blank_len - 16'd1;
            end else if (r_state == ST_BLANK && r_blank_cnt != '0) begin
                r_blank_cnt <= r_blank_cnt - 16'd1;
            end

            if (w_acq_start) begin
                r_samp_cnt <= '0;
            end else if (w_accept) begin
                r_samp_cnt <= r_samp_cnt + 16'd1;
            end

            // One register stage before the FIFO gives the accept-to-valid
            // latency of two edges; the full check happens at the write.
            r_wr_en   <= w_accept;
            r_wr_word <= w_wr_word;

            if (w_arm_acc) begin
                r_err <= '0;
            end else begin
                if (w_overlap) begin
                    r_err[ERR_OVERLAP] <= 1'b1;
                end
                if (r_wr_en && w_full) begin
                    r_err[ERR_OVERFLOW] <= 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output FIFO
    // -------------------------------------------------------------------------
    echo_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .i_clk     (clk),
        .i_rst_n   (rst),
        .i_wr_en   (r_wr_en),
        .i_wr_data (r_wr_word),
        .i_rd_en   (m_tready),
        .o_rd_data (w_rd_word),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign m_tdata  = w_rd_word[TDATA_W-1:0];
    assign m_tlast  = w_rd_word[TDATA_W];
    assign m_tvalid = !w_empty;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

    // -------------------------------------------------------------------------
    // Optional per-echo sum
    // -------------------------------------------------------------------------
`ifdef ACQ_ECHO_SUM_EN
    logic signed [31:0] r_acc;
    logic signed [31:0] r_sum;
    logic               r_sum_valid;
    logic signed [31:0] w_sample_ext;

    assign w_sample_ext = 32'(adc_data);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc       <= '0;
            r_sum       <= '0;
            r_sum_valid <= 1'b0;
        end else begin
            r_sum_valid <= 1'b0;
            if (w_acq_start) begin
                r_acc <= '0;
            end else if (w_accept) begin
                r_acc <= r_acc + w_sample_ext;
                if (w_last) begin
                    r_sum       <= r_acc + w_sample_ext;
                    r_sum_valid <= 1'b1;
                end
            end
        end
    end

    assign sum_data  = r_sum;
    assign sum_valid = r_sum_valid;
`else
    assign sum_data  = '0;
    assign sum_valid = 1'b0;
`endif

endmodule

// File: tb/tb_echo_acq_gate.sv
`timescale 1ns/1ps
module tb_echo_acq_gate;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned LOGN  = 32768;

    logic               clk = 1'b0;
    logic               rst;
    logic [15:0]        pulse_data;
    logic signed [15:0] adc_data;
    logic               adc_valid;
    logic               arm;
    logic [15:0]        blank_cycles;
    logic [15:0]        win_len;
    logic [15:0]        num_echoes;
    logic [31:0]        m_tdata;
    logic               m_tvalid;
    logic               m_tready;
    logic               m_tlast;
    logic               busy;
    logic               done;
    logic [1:0]         err;
    logic [31:0]        sum_data;
    logic               sum_valid;

    echo_acq_gate #(
        .FIFO_DEPTH (DEPTH),
        .DATA_W     (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pulse_data   (pulse_data),
        .adc_data     (adc_data),
        .adc_valid    (adc_valid),
        .arm          (arm),
        .blank_cycles (blank_cycles),
        .win_len      (win_len),
        .num_echoes   (num_echoes),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tlast      (m_tlast),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .sum_data     (sum_data),
        .sum_valid    (sum_valid)
    );

    always #4 clk = ~clk;

    // Input log indexed by the posedge that samples it; output beats and
    // strobes captured at negedge, where everything is stable.
    int unsigned cyc = 0;
    logic [15:0] lg_pd  [LOGN];
    logic        lg_v   [LOGN];
    logic [15:0] lg_adc [LOGN];
    logic [31:0] bq_data [$];
    logic        bq_last [$];
    logic [31:0] sq [$];
    int unsigned done_cnt = 0;
    int unsigned sumv_cnt = 0;

    always @(negedge clk) begin
        if (cyc < LOGN) begin
            lg_pd[cyc]  <= pulse_data;
            lg_v[cyc]   <= adc_valid;
            lg_adc[cyc] <= adc_data;
        end
        if (m_tvalid && m_tready) begin
            bq_data.push_back(m_tdata);
            bq_last.push_back(m_tlast);
        end
        if (done) done_cnt <= done_cnt + 1;
        if (sum_valid) begin
            sq.push_back(sum_data);
            sumv_cnt <= sumv_cnt + 1;
        end
        cyc <= cyc + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int unsigned vprob = 100;
    int unsigned rprob = 100;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs(input bit hold0);
        adc_valid = ($urandom_range(99) < vprob);
        adc_data  = 16'($urandom);
        m_tready  = hold0 ? 1'b0 : ($urandom_range(99) < rprob);
    endtask

    // Runs one armed train of n+1 pulses and compares the captured stream
    // against windows derived from the logged inputs.
    task automatic run_train(input int unsigned b, input int unsigned w, input int unsigned n,
                             input bit inject, input bit hold0, output int unsigned nb);
        int unsigned a_idx, end_idx, bq0, sq0, done0, w_eff, lp, gap;
        int unsigned k, echo, got, wend, t, kept;
        logic [31:0] s;
        logic [31:0] e_data [$];
        logic        e_last [$];
        logic [31:0] e_sum  [$];
        int unsigned pe [$];
        bit ov, of;

        bq0   = bq_data.size();
        sq0   = sq.size();
        done0 = done_cnt;
        w_eff = (w == 0) ? 1 : w;
        gap   = b + 3 * w_eff + 30;

        pulse_data   = '0;
        blank_cycles = 16'(b);
        win_len      = 16'(w);
        num_echoes   = 16'(n);
        arm          = 1'b1;
        a_idx        = cyc;
        step();
        arm = 1'b0;
        rand_inputs(hold0);
        check_val("busy_after_arm", busy, 1);

        for (int p = 0; p <= int'(n); p++) begin
            pulse_data = 16'h43CA;
            lp = $urandom_range(5, 2);
            for (int i = 0; i < int'(lp); i++) begin
                step();
                rand_inputs(hold0);
            end
            pulse_data = '0;
            for (int g = 0; g < int'(gap); g++) begin
                if (inject && p == 1 && g == int'(b) + 3) pulse_data = 16'h0101;
                if (inject && p == 1 && g == int'(b) + 5) pulse_data = 16'h0000;
                step();
                rand_inputs(hold0);
            end
        end

        for (int i = 0; i < 3000 && busy; i++) begin
            step();
            rand_inputs(hold0);
        end
        check_val("train_done_in_time", busy, 0);

        adc_valid = 1'b0;
        m_tready  = 1'b1;
        step();
        step();
        for (int i = 0; i < 64 && m_tvalid; i++) step();
        check_val("fifo_drained", m_tvalid, 0);
        end_idx = cyc;

        // Reference: pulse ends after arm, skip the first, each window takes
        // the first w_eff valid samples from pulse_end+blank+1; pulse ends up
        // to the last sample of a window are overlaps.
        for (int unsigned i = a_idx + 1; i < end_idx; i++)
            if (lg_pd[i] == 16'h0 && lg_pd[i-1] != 16'h0) pe.push_back(i);
        k = 1; echo = 0; ov = 0;
        while (echo < n && k < pe.size()) begin
            t = pe[k] + b + 1; got = 0; wend = 0; s = '0;
            while (got < w_eff && t < end_idx) begin
                if (lg_v[t]) begin
                    got++;
                    e_data.push_back({16'(echo), lg_adc[t]});
                    e_last.push_back(got == w_eff);
                    s = s + 32'(signed'(lg_adc[t]));
                    wend = t;
                end
                t++;
            end
            if (got < w_eff) break;
            e_sum.push_back(s);
            k++;
            while (k < pe.size() && pe[k] <= wend) begin
                ov = 1;
                k++;
            end
            echo++;
        end
        check_val("model_echoes", echo, n);

        of   = hold0 && (e_data.size() > DEPTH);
        kept = (hold0 && e_data.size() > DEPTH) ? DEPTH : e_data.size();
        nb   = bq_data.size() - bq0;
        check_val("beat_count", nb, kept);
        for (int unsigned i = 0; i < kept && i < nb; i++) begin
            check_val($sformatf("tdata[%0d]", i), bq_data[bq0 + i], e_data[i]);
            check_val($sformatf("tlast[%0d]", i), bq_last[bq0 + i], e_last[i]);
        end
        check_val("err", err, {ov, of});
        check_val("done_pulses", done_cnt - done0, 1);
`ifdef ACQ_ECHO_SUM_EN
        check_val("sum_count", sq.size() - sq0, e_sum.size());
        for (int unsigned i = 0; i < e_sum.size() && sq0 + i < sq.size(); i++)
            check_val($sformatf("sum[%0d]", i), sq[sq0 + i], e_sum[i]);
`else
        check_val("sum_data_off", sum_data, 0);
        check_val("sum_valid_off", sumv_cnt, 0);
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_tvalid"}, m_tvalid, 0);
        check_val({tag, "_tlast"}, m_tlast, 0);
        check_val({tag, "_tdata"}, m_tdata, 0);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_done"}, done, 0);
        check_val({tag, "_err"}, err, 0);
        check_val({tag, "_sum_data"}, sum_data, 0);
        check_val({tag, "_sum_valid"}, sum_valid, 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned nb, d0;
        rst = 1'b0; arm = 1'b0; pulse_data = '0; adc_valid = 1'b0; adc_data = '0;
        m_tready = 1'b0; blank_cycles = '0; win_len = '0; num_echoes = '0;
        repeat (3) step();
        check_reset_outputs("reset");
        rst = 1'b1;
        step();
        step();

        // Nominal train: 8 beats, tlast on beats 4 and 8.
        vprob = 100; rprob = 100;
        run_train(10, 4, 2, 1'b0, 1'b0, nb);
        check_val("nominal_beats", nb, 8);

        // Stalled sink: 16 kept, 4 dropped, overflow flag.
        run_train(3, 20, 1, 1'b0, 1'b1, nb);
        check_val("overflow_beats", nb, 16);

        // Extra pulse end inside an acquisition window.
        run_train(4, 8, 2, 1'b1, 1'b0, nb);
        check_val("overlap_beats", nb, 16);

        // Zero-echo train.
        d0 = done_cnt;
        num_echoes = 16'd0; blank_cycles = 16'd5; win_len = 16'd5; arm = 1'b1;
        step();
        arm = 1'b0;
        check_val("zero_busy", busy, 1);
        check_val("zero_done_early", done, 0);
        step();
        check_val("zero_done", done, 1);
        check_val("zero_busy_drop", busy, 0);
        step();
        check_val("zero_done_once", done, 0);
        check_val("zero_tvalid", m_tvalid, 0);
        step();
        check_val("zero_done_count", done_cnt - d0, 1);

`ifdef ACQ_ECHO_SUM_EN
        // Samples 1,2,3,-4 sum to 2.
        adc_valid = 1'b0; m_tready = 1'b1;
        blank_cycles = 16'd0; win_len = 16'd4; num_echoes = 16'd1; arm = 1'b1;
        step();
        arm = 1'b0;
        pulse_data = 16'h43CA; step(); step();
        pulse_data = 16'h0000; step(); step();
        pulse_data = 16'h43CA; step(); step();
        pulse_data = 16'h0000;
        step();
        adc_valid = 1'b1; adc_data = 16'sd1;
        step(); adc_data = 16'sd2;
        step(); adc_data = 16'sd3;
        step(); adc_data = -16'sd4;
        step(); adc_valid = 1'b0;
        check_val("sum_valid_pulse", sum_valid, 1);
        check_val("sum_value", sum_data, 32'd2);
        step();
        check_val("sum_valid_single", sum_valid, 0);
        for (int i = 0; i < 50 && busy; i++) step();
        repeat (4) step();
`endif

        // Reset in the middle of an acquisition window.
        adc_valid = 1'b1; m_tready = 1'b0;
        blank_cycles = 16'd2; win_len = 16'd50; num_echoes = 16'd1; arm = 1'b1;
        step();
        arm = 1'b0;
        pulse_data = 16'h43CA; repeat (3) step();
        pulse_data = 16'h0000; repeat (10) step();
        pulse_data = 16'h43CA; repeat (3) step();
        pulse_data = 16'h0000; repeat (10) step();
        check_val("pre_reset_tvalid", m_tvalid, 1);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        step();
        adc_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        run_train(3, 3, 1, 1'b0, 1'b0, nb);
        check_val("post_reset_beats", nb, 3);

        // Randomized trains.
        for (int r = 0; r < 8; r++) begin
            vprob = $urandom_range(100, 60);
            rprob = $urandom_range(100, 70);
            run_train($urandom_range(12, 0), $urandom_range(10, 0), $urandom_range(3, 1),
                      1'b0, 1'b0, nb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/echo_acq_gate.md
ECHO_ACQ_GATE -- requirements
Module: echo_acq_gate

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, output FIFO depth in samples, power of two, at least 4.
REQ-002 Parameter DATA_W, default 16, ADC sample width.
REQ-003 clk  in  1  single clock, 125 MHz; all logic on posedge.
REQ-004 rst  in  1  reset, asynchronous assert, active-low.
REQ-005 pulse_data  in  16  transmit amplitude word from the CPMG pulse generator; non-zero means pulse on.
REQ-006 adc_data  in  DATA_W  signed receiver sample.
REQ-007 adc_valid  in  1  adc_data is valid this cycle.
REQ-008 arm  in  1  one-cycle start strobe; latches the configuration inputs.
REQ-009 blank_cycles  in  16  ring-down blanking length in clocks after each refocusing pulse ends.
REQ-010 win_len  in  16  samples captured per echo.
REQ-011 num_echoes  in  16  echoes per train.
REQ-012 m_tdata  out  32  {echo_idx[15:0], sign-extended sample[15:0]}.
REQ-013 m_tvalid / m_tready / m_tlast  out/in/out  1 each; m_tlast marks the last sample of each echo window.
REQ-014 busy  out  1  high from an accepted arm until DONE.
REQ-015 done  out  1  one-cycle pulse when the train completes.
REQ-016 err  out  2  sticky flags {overlap, overflow}; cleared on an accepted arm.
REQ-017 sum_data  out  32  and sum_valid  out  1  per-echo sum (see Configuration).

Function
REQ-018 States: IDLE, WAIT_PULSE, BLANK, ACQ, DONE.
REQ-019 IDLE->WAIT_PULSE on arm; latch blank_cycles, win_len (0 treated as 1), num_echoes; clear echo_idx and err.
REQ-020 If the latched num_echoes is 0, the block goes IDLE->DONE->IDLE with no output.
REQ-021 Pulse end is the cycle where pulse_data==0 and the registered previous pulse_data!=0.
REQ-022 The first pulse end after arm (excitation pulse) is skipped; each later pulse end in WAIT_PULSE enters BLANK.
REQ-023 BLANK lasts exactly blank_cycles clocks (0 gives direct entry to ACQ on the next cycle), then enters ACQ.
REQ-024 ACQ accepts samples only when adc_valid=1, and stays in ACQ until win_len samples are accepted.
REQ-025 The last accepted sample of a window is written with tlast=1; echo_idx then increments; the block enters DONE if echo_idx reaches num_echoes, otherwise WAIT_PULSE.
REQ-026 DONE asserts done for one cycle, drops busy, and returns to IDLE.
REQ-027 A pulse end detected in BLANK or ACQ is not counted, sets err[1], and the current window continues.
REQ-028 A sample accepted while the FIFO is full is dropped, sets err[0], and still counts toward win_len.
REQ-029 The FIFO is first-word-fall-through: a sample accepted at edge N has m_tvalid=1 after edge N+1.
REQ-030 m_tdata and m_tlast are held stable while m_tvalid=1 and m_tready=0.
REQ-031 arm is ignored while busy=1.
REQ-032 FIFO contents keep draining after DONE; a new arm does not flush the FIFO.

Reset
REQ-033 On rst=0: state IDLE, FIFO empty, m_tvalid=0, m_tlast=0, m_tdata=0, busy=0, done=0, err=0, sum_data=0, sum_valid=0, echo_idx=0.
REQ-034 Reset asserted mid-train aborts immediately and discards FIFO contents.

Configuration
REQ-035 With ACQ_ECHO_SUM_EN defined: a 32-bit signed accumulator sums every accepted window sample, including dropped ones; the cycle after the last sample, sum_data holds the echo sum and sum_valid pulses for one cycle, with no backpressure; the accumulator clears at the start of each window.
REQ-036 Without ACQ_ECHO_SUM_EN: sum_data=0 and sum_valid=0 constantly, and no accumulator logic is present.

Structure
REQ-037 Package echo_acq_pkg holds the state enum, DATA_W default, the tdata field widths and offsets, and the err bit indices.
REQ-038 One sub-module, echo_fifo: a synchronous FWFT FIFO with asynchronous active-low reset, full and empty flags, and depth FIFO_DEPTH.

Verification
REQ-039 arm with blank=10, win=4, num=2; pulse_data trains 0x43CA/0 with three pulses; adc_valid=1 -> 8 beats, echo_idx 0,0,0,0,1,1,1,1, tlast on beats 4 and 8, done pulse once.
REQ-040 m_tready=0 during win=20, FIFO_DEPTH=16 -> 16 samples kept, 4 dropped, err=2'b01.
REQ-041 Extra pulse end during ACQ -> err=2'b10, window length unchanged, echo count unchanged.
REQ-042 arm with num_echoes=0 -> done pulses 2 cycles after arm, m_tvalid stays 0.
REQ-043 rst low mid-ACQ -> all outputs at reset values the same cycle; a following arm runs cleanly.
REQ-044 ACQ_ECHO_SUM_EN, samples 1,2,3,-4 -> sum_data=2 with sum_valid one cycle after the 4th sample.
